// File: rtl/wave_synth.sv
// DDS tone generator: phase accumulator, quarter-wave sine table, four waveforms, amplitude scaling.
// Latency 2 cycles tick->sample_valid, no backpressure (one sample per tick). Optional: WAVE_SYNTH_PHASE_OFFSET_EN.
module wave_synth #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 8,
    parameter int AMP_W   = 8,
    localparam int OUT_W  = ADDR_W + AMP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_tick,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               phase_clr,
    input  logic [1:0]         mode,
    input  logic [AMP_W-1:0]   amp,
`ifdef WAVE_SYNTH_PHASE_OFFSET_EN
    input  logic [PHASE_W-1:0] phase_ofs,
`endif
    output logic [OUT_W-1:0]   sample_out,
    output logic               sample_valid
);

    localparam int Q = 2 ** (ADDR_W - 2);
    localparam logic signed [ADDR_W-1:0] PEAK = ADDR_W'((2 ** (ADDR_W - 1)) - 1);

    // Elaboration-time sine via Taylor series, rounded to nearest.
    function automatic logic [ADDR_W-2:0] tab_val(input int i);
        real x, term, s;
        x    = 3.14159265358979 * real'(i) / (2.0 * real'(Q));
        s    = x;
        term = x;
        for (int k = 1; k < 10; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        return (ADDR_W-1)'($rtoi(s * real'((2 ** (ADDR_W - 1)) - 1) + 0.5));
    endfunction

    logic [ADDR_W-2:0] qtab [0:Q];
    for (genvar g = 0; g <= Q; g++) begin : g_tab
        assign qtab[g] = tab_val(g);
    end

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] addr_phase;
`ifdef WAVE_SYNTH_PHASE_OFFSET_EN
    assign addr_phase = phase + phase_ofs;
`else
    assign addr_phase = phase;
`endif

    logic [ADDR_W-1:0] addr;
    assign addr = addr_phase[PHASE_W-1 -: ADDR_W];
    logic unused_phase_lo;
    assign unused_phase_lo = ^addr_phase[PHASE_W-ADDR_W-1:0];

    logic                     msb;
    logic [ADDR_W-2:0]        tidx;
    logic [ADDR_W-2:0]        tmag;
    logic signed [ADDR_W-1:0] sine_w, square_w, saw_w, tri_w, wave_c;
    logic [ADDR_W-1:0]        saw_raw;
    logic [ADDR_W-2:0]        tri_v;
    logic signed [ADDR_W:0]   tri_ext;

    assign msb = addr[ADDR_W-1];

    always_comb begin
        tidx     = addr[ADDR_W-2] ? ((ADDR_W-1)'(Q) - {1'b0, addr[ADDR_W-3:0]})
                                  : {1'b0, addr[ADDR_W-3:0]};
        tmag     = qtab[tidx];
        sine_w   = msb ? -$signed({1'b0, tmag}) : $signed({1'b0, tmag});
        square_w = msb ? -PEAK : PEAK;
        // Offset-binary to two's complement; -2^(ADDR_W-1) clamps to keep the wave symmetric.
        saw_raw  = {~msb, addr[ADDR_W-2:0]};
        saw_w    = (saw_raw == {1'b1, {(ADDR_W-1){1'b0}}}) ? -PEAK : $signed(saw_raw);
        tri_v    = msb ? ~addr[ADDR_W-2:0] : addr[ADDR_W-2:0];
        tri_ext  = $signed({1'b0, tri_v, 1'b0}) - $signed({1'b0, PEAK});
        tri_w    = tri_ext[ADDR_W-1:0];
        wave_c   = sine_w;
        case (mode)
            2'd0:    wave_c = sine_w;
            2'd1:    wave_c = square_w;
            2'd2:    wave_c = saw_w;
            default: wave_c = tri_w;
        endcase
    end

    logic                     s1_vld;
    logic signed [ADDR_W-1:0] s1_wave;
    logic [AMP_W-1:0]         s1_amp;
    logic signed [OUT_W-1:0]  prod;

    assign prod = OUT_W'(s1_wave) * OUT_W'($signed({1'b0, s1_amp}));

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= '0;
            s1_vld       <= 1'b0;
            s1_wave      <= '0;
            s1_amp       <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            if (phase_clr)
                phase <= '0;
            else if (sample_tick)
                phase <= phase + freq_word;
            s1_vld <= sample_tick;
            if (sample_tick) begin
                s1_wave <= wave_c;
                s1_amp  <= amp;
            end
            sample_valid <= s1_vld;
            if (s1_vld)
                sample_out <= prod;
        end
    end

endmodule

// File: tb/tb_wave_synth.sv
// Scoreboard bench for wave_synth: stimulus pushes expected samples, a negedge monitor pops and checks.
module tb_wave_synth;
    localparam int OUT_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sample_tick = 1'b0;
    logic [23:0]       freq_word = '0;
    logic              phase_clr = 1'b0;
    logic [1:0]        mode = '0;
    logic [7:0]        amp = '0;
`ifdef WAVE_SYNTH_PHASE_OFFSET_EN
    logic [23:0]       phase_ofs = '0;
`endif
    logic [OUT_W-1:0]  sample_out;
    logic              sample_valid;

    wave_synth #(.PHASE_W(24), .ADDR_W(8), .AMP_W(8)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .freq_word(freq_word),
        .phase_clr(phase_clr), .mode(mode), .amp(amp),
`ifdef WAVE_SYNTH_PHASE_OFFSET_EN
        .phase_ofs(phase_ofs),
`endif
        .sample_out(sample_out), .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { int val; int cyc; string tag; } exp_t;
    exp_t sbq[$];

    // Reference sine sample for a full-cycle address (256 steps, peak 127).
    function automatic int sine_ref(input int a);
        real r;
        r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 256.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    task automatic check(input string tag, input int got, input int req);
        n_chk++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", tag, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick(input int expv, input string tag);
        exp_t e;
        e.val = expv;
        e.cyc = cyc + 2;
        e.tag = tag;
        sbq.push_back(e);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
    endtask

    task automatic clear_phase();
        phase_clr = 1'b1;
        step(1);
        phase_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s: no sample_valid by cycle %0d, required at cycle %0d", e.tag, cyc, e.cyc);
        end
        if (sample_valid) begin
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: sample_valid at cycle %0d with value %0d, required none",
                         cyc, $signed(sample_out));
            end else begin
                e = sbq.pop_front();
                if ($signed(sample_out) != e.val || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d",
                             e.tag, $signed(sample_out), cyc, e.val, e.cyc);
                end
            end
        end
    end

    int sq_exp  [4] = '{127, 127, -127, -127};
    int saw_exp [4] = '{-127, -1, 0, 127};
    int tri_exp [4] = '{-127, 127, 127, -127};
    int amp_exp [4] = '{0, 32385, 0, -32385};

    initial begin
        int e4 [4];
        int r;
        step(3);
        check("reset_sample_out", int'(sample_out), 0);
        check("reset_sample_valid", int'(sample_valid), 0);
        reset = 1'b0;
        step(1);

        // Sine sweep: one table step per tick, then one extra tick back at address 0.
        freq_word = 24'h010000;
        mode = 2'd0;
        amp = 8'd1;
        for (int k = 0; k <= 256; k++)
            do_tick(sine_ref(k % 256), $sformatf("sine_addr%0d", k % 256));
        step(3);

        clear_phase();
        freq_word = 24'h400000;
        amp = 8'd255;
        for (int k = 0; k < 4; k++)
            do_tick(amp_exp[k], $sformatf("sine_amp255_addr%0d", k * 64));
        step(3);

        // Addresses 0, 127, 128, 255 via varying tuning words.
        amp = 8'd1;
        for (int m = 1; m <= 3; m++) begin
            clear_phase();
            mode = 2'(m);
            for (int k = 0; k < 4; k++)
                e4[k] = (m == 1) ? sq_exp[k] : (m == 2) ? saw_exp[k] : tri_exp[k];
            freq_word = 24'h7F0000; do_tick(e4[0], $sformatf("mode%0d_addr0", m));
            freq_word = 24'h010000; do_tick(e4[1], $sformatf("mode%0d_addr127", m));
            freq_word = 24'h7F0000; do_tick(e4[2], $sformatf("mode%0d_addr128", m));
            do_tick(e4[3], $sformatf("mode%0d_addr255", m));
        end
        step(3);

        clear_phase();
        mode = 2'd2;
        freq_word = 24'hFFFFFF;
        do_tick(-127, "wrap_addr0");
        do_tick(127, "wrap_phase_ffffff");
        do_tick(127, "wrap_phase_fffffe");
        step(2);

        clear_phase();
        freq_word = 24'h400000;
        do_tick(-127, "clr_pre_addr0");
        phase_clr = 1'b1;
        do_tick(-64, "clr_tick_addr64");
        phase_clr = 1'b0;
        do_tick(-127, "clr_after_addr0");

        freq_word = 24'h0;
        for (int k = 0; k < 3; k++)
            do_tick(-64, $sformatf("freq0_rep%0d", k));
        step(3);

`ifdef WAVE_SYNTH_PHASE_OFFSET_EN
        clear_phase();
        mode = 2'd0;
        freq_word = 24'h010000;
        phase_ofs = 24'h400000;
        do_tick(127, "ofs_addr64");
        do_tick(sine_ref(65), "ofs_addr65");
        phase_ofs = 24'h0;
        do_tick(sine_ref(2), "ofs_removed_addr2");
        step(3);
`endif

        // Reset lands while two samples are still in the pipeline.
        clear_phase();
        mode = 2'd2;
        amp = 8'd2;
        freq_word = 24'h100000;
        do_tick(-254, "pre_rst_addr0");
        do_tick(-224, "pre_rst_addr16");
        do_tick(-192, "inflight_addr32");
        reset = 1'b1;
        sample_tick = 1'b1;
        r = cyc;
        while (sbq.size() > 0 && sbq[$].cyc > r)
            void'(sbq.pop_back());
        step(1);
        reset = 1'b0;
        sample_tick = 1'b0;
        check("midrst_sample_out", int'(sample_out), 0);
        check("midrst_sample_valid", int'(sample_valid), 0);
        step(2);
        do_tick(-254, "post_rst_addr0");
        do_tick(-224, "post_rst_addr16");
        step(5);
        check("hold_sample_out", int'($signed(sample_out)), -224);
        check("hold_sample_valid", int'(sample_valid), 0);

        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d samples outstanding, required 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
